// File: rtl/param_data_memory.sv
// Byte-enabled word memory that zero-fills itself after reset, with a 1-cycle registered read.
// Build option WRITE_FORWARD_EN: same-address read-during-write returns the merged word (write-first); otherwise read-first.
module param_data_memory #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    memRead,
   input  logic                    memWrite,
   input  logic [ADDR_WIDTH-1:0]   lineNumber,
   input  logic [DATA_WIDTH-1:0]   memIn,
   input  logic [DATA_WIDTH/8-1:0] byteEn,
   output logic [DATA_WIDTH-1:0]   memOut,
   output logic                    memValid,
   output logic                    busy,
   output logic                    addrErr
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [ADDR_WIDTH-1:0]   r_clr_ptr;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [DATA_WIDTH-1:0]   r_mem_out;
   logic                    r_mem_valid;
   logic                    r_addr_err;

   logic                    w_in_range;
   logic                    w_rd_acc;
   logic                    w_wr_acc;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic [DATA_WIDTH-1:0]   w_old_word;
   logic [DATA_WIDTH-1:0]   w_merged;
   logic [DATA_WIDTH-1:0]   w_rd_data;

   // Out-of-range addresses are clamped to word 0 for the array lookup; the result is never used.
   assign w_in_range = ({1'b0, lineNumber} < DEPTH_W);
   assign w_idx      = w_in_range ? lineNumber : '0;
   assign w_rd_acc   = (r_state == READY) && memRead;
   assign w_wr_acc   = (r_state == READY) && memWrite;
   assign w_old_word = r_mem[w_idx];

   always_comb begin
      w_merged = w_old_word;
      for (int k = 0; k < LANES; k++) begin
         if (byteEn[k]) begin
            w_merged[8*k +: 8] = memIn[8*k +: 8];
         end
      end
   end

`ifdef WRITE_FORWARD_EN
   assign w_rd_data = w_wr_acc ? w_merged : w_old_word;
`else
   assign w_rd_data = w_old_word;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         CLEAR:   if (r_clr_ptr == LAST_ADDR) w_next_state = READY;
         READY:   w_next_state = READY;
         default: w_next_state = CLEAR;
      endcase
   end

   // The merged word is written back whole, so lanes with byteEn=0 rewrite their old value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
         end else if (w_wr_acc && w_in_range) begin
            r_mem[w_idx] <= w_merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_ptr   <= '0;
         r_mem_out   <= '0;
         r_mem_valid <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
         end
         r_mem_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_mem_out <= w_in_range ? w_rd_data : '0;
         end
         r_addr_err <= (w_rd_acc || w_wr_acc) && !w_in_range;
      end
   end

   assign busy     = (r_state == CLEAR);
   assign memOut   = r_mem_out;
   assign memValid = r_mem_valid;
   assign addrErr  = r_addr_err;

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory built with 32-bit words and DEPTH=100.
module tb_param_data_memory;

   localparam int DW    = 32;
   localparam int DEPTH = 100;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          memRead;
   logic          memWrite;
   logic [AW-1:0] lineNumber;
   logic [DW-1:0] memIn;
   logic [3:0]    byteEn;
   logic [DW-1:0] memOut;
   logic          memValid;
   logic          busy;
   logic          addrErr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   param_data_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
      .lineNumber(lineNumber), .memIn(memIn), .byteEn(byteEn),
      .memOut(memOut), .memValid(memValid), .busy(busy), .addrErr(addrErr)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      memRead  = 1'b0;
      memWrite = 1'b0;
      byteEn   = 4'b0000;
      memIn    = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      memWrite = 1'b1; memRead = 1'b0; lineNumber = a; memIn = d; byteEn = be;
      tick;
      idle;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      memRead = 1'b1; memWrite = 1'b0; lineNumber = a;
      tick;
      idle;
   endtask

   // Counts cycles until busy falls, bounded; also reports any memValid/addrErr seen meanwhile.
   task automatic wait_ready(output int cnt, output bit saw_valid, output bit saw_err);
      cnt = 0; saw_valid = 0; saw_err = 0;
      while (busy === 1'b1 && cnt < 300) begin
         tick;
         cnt++;
         if (memValid !== 1'b0) saw_valid = 1;
         if (addrErr !== 1'b0) saw_err = 1;
      end
   endtask

   task automatic test_reset;
      int cnt; bit sv, se;
      reset = 1'b1; idle; lineNumber = '0;
      tick; tick;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b want=1", busy); end
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", memValid); end
      n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL reset_adderr got=%b want=0", addrErr); end
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL reset_memout got=%h want=0", memOut); end
      reset = 1'b0;
      memRead = 1'b1; lineNumber = 7'd5;
      wait_ready(cnt, sv, se);
      idle;
      n_cmp++; if (cnt !== 100) begin n_err++; $display("FAIL sweep_len got=%0d want=100", cnt); end
      n_cmp++; if (sv !== 1'b0) begin n_err++; $display("FAIL read_while_busy valid got=%b want=0", sv); end
      n_cmp++; if (se !== 1'b0) begin n_err++; $display("FAIL read_while_busy adderr got=%b want=0", se); end
      rd(7'd99);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL last_word_cleared got=%h want=0", memOut); end
      n_cmp++; if (memValid !== 1'b1) begin n_err++; $display("FAIL last_word_valid got=%b want=1", memValid); end
      tick;
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL valid_drop got=%b want=0", memValid); end
   endtask

   task automatic test_byte_en;
      wr(7'd3, 32'hAABBCCDD, 4'b1111);
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL write_no_valid got=%b want=0", memValid); end
      wr(7'd3, 32'h11223344, 4'b0101);
      wr(7'd3, 32'h99999999, 4'b0000);
      rd(7'd3);
      n_cmp++; if (memOut !== 32'hAA22CC44) begin n_err++; $display("FAIL byte_en_merge got=%h want=aa22cc44", memOut); end
      n_cmp++; if (memValid !== 1'b1) begin n_err++; $display("FAIL byte_en_valid got=%b want=1", memValid); end
      tick;
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL byte_en_pulse got=%b want=0", memValid); end
      n_cmp++; if (memOut !== 32'hAA22CC44) begin n_err++; $display("FAIL memout_hold got=%h want=aa22cc44", memOut); end
   endtask

   task automatic test_rdw;
      logic [DW-1:0] exp1, exp2;
`ifdef WRITE_FORWARD_EN
      exp1 = 32'h00000034; exp2 = 32'h0000FF34;
`else
      exp1 = 32'h00000012; exp2 = 32'h00000034;
`endif
      wr(7'd9, 32'h00000012, 4'b1111);
      memRead = 1'b1; memWrite = 1'b1; lineNumber = 7'd9; memIn = 32'h00000034; byteEn = 4'b1111;
      tick; idle;
      n_cmp++; if (memOut !== exp1) begin n_err++; $display("FAIL rdw_full got=%h want=%h", memOut, exp1); end
      rd(7'd9);
      n_cmp++; if (memOut !== 32'h00000034) begin n_err++; $display("FAIL rdw_stored got=%h want=00000034", memOut); end
      memRead = 1'b1; memWrite = 1'b1; lineNumber = 7'd9; memIn = 32'hFFFFFFFF; byteEn = 4'b0010;
      tick; idle;
      n_cmp++; if (memOut !== exp2) begin n_err++; $display("FAIL rdw_partial got=%h want=%h", memOut, exp2); end
      rd(7'd9);
      n_cmp++; if (memOut !== 32'h0000FF34) begin n_err++; $display("FAIL rdw_partial_stored got=%h want=0000ff34", memOut); end
   endtask

   task automatic test_addr_err;
      wr(7'd100, 32'hFFFFFFFF, 4'b1111);
      n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL wr_oob_err got=%b want=1", addrErr); end
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL wr_oob_valid got=%b want=0", memValid); end
      tick;
      n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL adderr_pulse got=%b want=0", addrErr); end
      rd(7'd100);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL rd_oob_data got=%h want=0", memOut); end
      n_cmp++; if (memValid !== 1'b1) begin n_err++; $display("FAIL rd_oob_valid got=%b want=1", memValid); end
      n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL rd_oob_err got=%b want=1", addrErr); end
      rd(7'd99);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL rd_99_data got=%h want=0", memOut); end
      n_cmp++; if (addrErr !== 1'b0) begin n_err++; $display("FAIL rd_99_err got=%b want=0", addrErr); end
      rd(7'd0);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL oob_no_alias got=%h want=0", memOut); end
      rd(7'd127);
      n_cmp++; if (addrErr !== 1'b1) begin n_err++; $display("FAIL rd_127_err got=%b want=1", addrErr); end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] exp;
      wr(7'd1, 32'h01, 4'b1111);
      wr(7'd2, 32'h02, 4'b1111);
      wr(7'd3, 32'h03, 4'b1111);
      memRead = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         lineNumber = AW'(i);
         tick;
         exp = DW'(i);
         n_cmp++; if (memOut !== exp) begin n_err++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, memOut, exp); end
         n_cmp++; if (memValid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, memValid); end
      end
      idle;
      tick;
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL b2b_end got=%b want=0", memValid); end
   endtask

   task automatic test_reset_mid_sweep;
      int cnt; bit sv, se;
      wr(7'd10, 32'h5A, 4'b1111);
      wr(7'd20, 32'h5A, 4'b1111);
      rd(7'd10);
      n_cmp++; if (memOut !== 32'h5A) begin n_err++; $display("FAIL pre_reset_data got=%h want=0000005a", memOut); end
      // Reset with a read pending: the read must be discarded.
      reset = 1'b1; memRead = 1'b1; lineNumber = 7'd20;
      tick;
      idle; reset = 1'b0;
      n_cmp++; if (memValid !== 1'b0) begin n_err++; $display("FAIL reset_discard got=%b want=0", memValid); end
      for (int i = 0; i < 50; i++) tick;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_sweep_busy got=%b want=1", busy); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      wait_ready(cnt, sv, se);
      n_cmp++; if (cnt !== 100) begin n_err++; $display("FAIL restart_len got=%0d want=100", cnt); end
      rd(7'd10);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL cleared_10 got=%h want=0", memOut); end
      rd(7'd20);
      n_cmp++; if (memOut !== 32'h0) begin n_err++; $display("FAIL cleared_20 got=%h want=0", memOut); end
   endtask

   initial begin
      test_reset;
      test_byte_en;
      test_rdw;
      test_addr_err;
      test_back_to_back;
      test_reset_mid_sweep;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: word width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL provide parameter DEPTH, default 128: number of words; legal range is 2 to 4096, and it need not be a power of two.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 7: lineNumber width; it SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-004 SHALL derive LANES = DATA_WIDTH/8 internally: the number of byte lanes.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 memRead  input  1  read request for the current cycle.
REQ-008 memWrite  input  1  write request for the current cycle.
REQ-009 lineNumber  input  ADDR_WIDTH  word address.
REQ-010 memIn  input  DATA_WIDTH  write data.
REQ-011 byteEn  input  LANES  per-byte write enable; bit k covers memIn[8k+7:8k].
REQ-012 memOut  output  DATA_WIDTH  registered read data.
REQ-013 memValid  output  1  one-cycle pulse when memOut is updated by an accepted read.
REQ-014 busy  output  1  high while the clear sweep is running; requests are not accepted.
REQ-015 addrErr  output  1  one-cycle pulse when an accepted request has lineNumber >= DEPTH.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and READY; busy SHALL equal (state == CLEAR).
REQ-017 In CLEAR, SHALL write zero to word clrPtr each cycle, incrementing clrPtr from 0 to DEPTH-1.
REQ-018 SHALL transition CLEAR->READY on the cycle after the write to word DEPTH-1, so busy is high for exactly DEPTH cycles after reset deasserts.
REQ-019 In CLEAR, SHALL ignore memRead and memWrite: no memory update, no memValid, no addrErr.
REQ-020 In READY, SHALL accept a read when memRead=1: memOut = word[lineNumber] and memValid=1, both on the next edge (1-cycle latency).
REQ-021 When no read is accepted, SHALL hold memOut and drive memValid=0.
REQ-022 In READY, SHALL accept a write when memWrite=1: only lanes with byteEn[k]=1 are updated, other lanes keep their value; byteEn=0 is a legal no-op.
REQ-023 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-024 Simultaneous read and write to the same address SHALL follow REQ-033/REQ-034.
REQ-025 For an accepted request with lineNumber >= DEPTH: the write SHALL be dropped; a read SHALL return memOut=0 with memValid=1; addrErr SHALL pulse for one cycle.
REQ-026 Back-to-back reads SHALL be supported at one per cycle, with memValid held high across consecutive accepted reads.

Reset
REQ-027 On reset=1 at an edge, SHALL set memOut=0, memValid=0, addrErr=0, clrPtr=0 and state=CLEAR; busy is then high from the following cycle.
REQ-028 Reset asserted during CLEAR SHALL restart the sweep at address 0.
REQ-029 Reset asserted during READY SHALL discard any request presented in that cycle.
REQ-030 Reset SHALL take precedence over all requests.
REQ-031 Memory contents SHALL be all-zero once busy falls; the sweep, not initial blocks, SHALL guarantee this.

Configuration
REQ-032 SHALL use macro WRITE_FORWARD_EN to select same-address read-during-write behaviour.
REQ-033 With WRITE_FORWARD_EN defined: a same-address read SHALL return the merged word, i.e. new bytes where byteEn=1 and old bytes elsewhere (write-first).
REQ-034 Without WRITE_FORWARD_EN: a same-address read SHALL return the pre-write word (read-first).
REQ-035 With or without WRITE_FORWARD_EN, the stored result of the write SHALL be identical.

Verification
REQ-036 Reset, DEPTH=128: pulse reset for 1 cycle -> busy high exactly 128 cycles; a read of 0x05 issued while busy is ignored (no memValid); a read of 0x7F after busy falls returns memOut=0x00.
REQ-037 DATA_WIDTH=32: write 0xAABBCCDD to addr 3 with byteEn=4'b1111, then write 0x11223344 with byteEn=4'b0101, then read addr 3 -> memOut=0xAA22CC44 one cycle after the read, memValid pulse width 1.
REQ-038 DATA_WIDTH=8: word 9 holds 0x12; write 0x34 and read word 9 in the same cycle -> memOut=0x34 with WRITE_FORWARD_EN, 0x12 without; a following read of 9 returns 0x34 in both builds.
REQ-039 DEPTH=100, ADDR_WIDTH=7: write 0xFF to addr 100 -> addrErr pulses and nothing is stored; read addr 100 -> memOut=0x00, memValid=1, addrErr=1; read addr 99 -> 0x00 with no addrErr.
REQ-040 Reset reasserted at sweep cycle 50 -> busy remains high for 128 further cycles after reset deasserts; words previously written 0x5A read back 0x00.
REQ-041 Reads of addrs 1,2,3 on consecutive cycles after writing 0x01,0x02,0x03 -> memOut=0x01,0x02,0x03 on consecutive cycles with memValid high for 3 cycles.
